// File: rtl/gauss_ppl_pkg.sv
// Shared definitions for the elastic handshake pipeline (ppl_hs_dly family):
// stage state encoding and the occupancy counter width helper.
package gauss_ppl_pkg;

  // Per-stage occupancy: nothing held, main register held, main + skid held.
  typedef enum logic [1:0] {
    PPL_EMPTY,
    PPL_BUSY,
    PPL_FULL
  } ppl_st_t;

  // Default payload width used by the top level.
  localparam int PPL_DATA_WIDTH_DEF = 32;

  // Width of a counter that must represent 0 .. 2*depth beats.
  // A zero-depth pipe still exposes a 1-bit (constant zero) counter.
  function automatic int ppl_occ_w(input int depth);
    if (depth <= 0) begin
      return 1;
    end
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/ppl_skid_blk.sv
// One skid-buffer stage of the elastic pipeline.
// Holds up to two beats (main + skid). Upstream ready is a register that
// mirrors "next state is not FULL", so it never depends on the downstream
// ready in the same cycle. The payload registers carry no reset.
module ppl_skid_blk
  import gauss_ppl_pkg::*;
#(
  parameter int DATA_WH = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [DATA_WH-1:0] d_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [DATA_WH-1:0] d_o
);

  ppl_st_t            r_state;
  ppl_st_t            w_state_next;
  logic               r_rdy;
  logic [DATA_WH-1:0] r_main;
  logic [DATA_WH-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main_d;
  logic w_load_main_skid;
  logic w_load_skid;

  // Ready is forced low while held in reset because r_rdy resets to 0.
  assign w_in_fire  = valid_i & r_rdy;
  assign w_out_fire = (r_state != PPL_EMPTY) & ready_i;

  // Next-state and register-load decode for the three-state stage.
  always_comb begin
    w_state_next     = r_state;
    w_load_main_d    = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      PPL_EMPTY: begin
        if (w_in_fire) begin
          w_state_next  = PPL_BUSY;
          w_load_main_d = 1'b1;
        end
      end
      PPL_BUSY: begin
        if (w_in_fire && !w_out_fire) begin
          // Downstream stalled: park the new beat behind the one in main.
          w_state_next = PPL_FULL;
          w_load_skid  = 1'b1;
        end else if (!w_in_fire && w_out_fire) begin
          w_state_next = PPL_EMPTY;
        end else if (w_in_fire && w_out_fire) begin
          w_load_main_d = 1'b1;
        end
      end
      PPL_FULL: begin
        // Upstream ready is low here, so only the drain case exists.
        if (w_out_fire) begin
          w_state_next     = PPL_BUSY;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = PPL_EMPTY;
      end
    endcase
  end

  // Control state and registered upstream ready, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= PPL_EMPTY;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rdy   <= (w_state_next != PPL_FULL);
    end
  end

  // Payload storage; contents are only meaningful while the state says so.
  always_ff @(posedge clk_i) begin
    if (w_load_main_d) begin
      r_main <= d_i;
    end else if (w_load_main_skid) begin
      r_main <= r_skid;
    end
    if (w_load_skid) begin
      r_skid <= d_i;
    end
  end

  assign ready_o = r_rdy;
  assign valid_o = (r_state != PPL_EMPTY);
  assign d_o     = r_main;

endmodule

// File: rtl/ppl_hs_dly.sv
// Elastic pipeline delay: a chain of PIPE_DEPTH skid stages with valid/ready
// handshake. Latency PIPE_DEPTH cycles, one beat per cycle, capacity
// 2*PIPE_DEPTH beats. PIPE_DEPTH=0 wires straight through.
// Optional macro PPL_HS_OCC_CNT_EN adds the occ_o beat-occupancy output.
module ppl_hs_dly
  import gauss_ppl_pkg::*;
#(
  parameter int DATA_WIDTH = PPL_DATA_WIDTH_DEF,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] d_o
`ifdef PPL_HS_OCC_CNT_EN
  ,
  output logic [ppl_occ_w(PIPE_DEPTH)-1:0] occ_o
`endif
);

  if (PIPE_DEPTH == 0) begin : g_pass
    // No storage: the handshake is purely combinational.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk_i ^ rst_n_i;
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign d_o     = d_i;
  end else begin : g_chain
    // Index 0 is the block input, index PIPE_DEPTH the block output.
    logic [PIPE_DEPTH:0]                 w_vld;
    logic [PIPE_DEPTH:0]                 w_rdy;
    logic [PIPE_DEPTH:0][DATA_WIDTH-1:0] w_dat;

    assign w_vld[0]          = valid_i;
    assign w_dat[0]          = d_i;
    assign ready_o           = w_rdy[0];
    assign w_rdy[PIPE_DEPTH] = ready_i;
    assign valid_o           = w_vld[PIPE_DEPTH];
    assign d_o               = w_dat[PIPE_DEPTH];

    for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
      ppl_skid_blk #(
        .DATA_WH(DATA_WIDTH)
      ) u_stage (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .valid_i(w_vld[gi]),
        .ready_o(w_rdy[gi]),
        .d_i    (w_dat[gi]),
        .valid_o(w_vld[gi+1]),
        .ready_i(w_rdy[gi+1]),
        .d_o    (w_dat[gi+1])
      );
    end
  end

`ifdef PPL_HS_OCC_CNT_EN
  localparam int OCC_W = ppl_occ_w(PIPE_DEPTH);

  if (PIPE_DEPTH == 0) begin : g_occ_tie
    // A pass-through never holds a beat.
    assign occ_o = '0;
  end else begin : g_occ
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic [OCC_W-1:0] r_occ;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = valid_i & ready_o;
    assign w_out_fire = valid_o & ready_i;

    // Track beats held: bounded by the chain capacity since ready_o gates entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_occ <= '0;
      end else if (w_in_fire && !w_out_fire) begin
        r_occ <= r_occ + OCC_ONE;
      end else if (!w_in_fire && w_out_fire) begin
        r_occ <= r_occ - OCC_ONE;
      end
    end

    assign occ_o = r_occ;
  end
`endif

endmodule

// File: tb/tb_ppl_hs_dly.sv
// Bench for ppl_hs_dly: one DUT per depth 0..4 sharing clock and reset.
// Occupancy checks are compiled in only when PPL_HS_OCC_CNT_EN is defined.
module tb_ppl_hs_dly;
`ifdef PPL_HS_OCC_CNT_EN
  import gauss_ppl_pkg::*;
`endif

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [4:0]         v_in  = '0;
  logic [4:0]         r_in  = '0;
  logic [4:0][DW-1:0] din   = '0;
  logic [4:0]         v_out;
  logic [4:0]         rdy_o;
  logic [4:0][DW-1:0] dout;
`ifdef PPL_HS_OCC_CNT_EN
  logic [4:0][3:0]    occ_v;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
`ifdef PPL_HS_OCC_CNT_EN
    logic [ppl_occ_w(gi)-1:0] occ_w;
    assign occ_v[gi] = 4'(occ_w);
`endif
    ppl_hs_dly #(
      .DATA_WIDTH(DW),
      .PIPE_DEPTH(gi)
    ) u_dut (
`ifdef PPL_HS_OCC_CNT_EN
      .occ_o  (occ_w),
`endif
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .valid_i(v_in[gi]),
      .ready_o(rdy_o[gi]),
      .d_i    (din[gi]),
      .valid_o(v_out[gi]),
      .ready_i(r_in[gi]),
      .d_o    (dout[gi])
    );
  end

  // Drive one cycle on DUT dp (called at a negedge), update the scoreboard
  // with the fires that happen at the coming posedge, return at next negedge.
  task automatic step(input int dp, input bit vin, input logic [DW-1:0] dv, input bit rin,
                      output bit ofire, output logic [DW-1:0] obs, output logic [DW-1:0] exp,
                      output bit hexp, output bit ifire);
    v_in[dp] = vin;
    din[dp]  = dv;
    r_in[dp] = rin;
    ifire = vin & rdy_o[dp];
    ofire = v_out[dp] & rin;
    obs   = dout[dp];
    exp   = '0;
    hexp  = 1'b0;
    if (ofire && sb_q.size() > 0) begin
      exp  = sb_q.pop_front();
      hexp = 1'b1;
    end
    if (ifire) sb_q.push_back(dv);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v_in = '0; r_in = '0; din = '0;
    repeat (2) @(negedge clk);
    for (int dp = 1; dp < 5; dp++) begin
      n_checks++;
      if (v_out[dp] !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid d%0d: got %b expected 0", dp, v_out[dp]);
      end
      n_checks++;
      if (rdy_o[dp] !== 1'b0) begin
        n_fail++; $display("FAIL reset_ready d%0d: got %b expected 0", dp, rdy_o[dp]);
      end
`ifdef PPL_HS_OCC_CNT_EN
      n_checks++;
      if (occ_v[dp] !== 4'd0) begin
        n_fail++; $display("FAIL reset_occ d%0d: got %0d expected 0", dp, occ_v[dp]);
      end
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int dp = 1; dp < 5; dp++) begin
      n_checks++;
      if (rdy_o[dp] !== 1'b1 || v_out[dp] !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset d%0d: got ready=%b valid=%b expected ready=1 valid=0",
                 dp, rdy_o[dp], v_out[dp]);
      end
    end
  endtask

  task automatic test_pipeline();
    bit ofire, hexp, ifire;
    logic [DW-1:0] obs, exp;
    sb_q.delete();
    for (int s = 0; s < 15; s++) begin
      step(3, s < 10, DW'(s), 1'b1, ofire, obs, exp, hexp, ifire);
      n_checks++;
      if (ofire !== (s >= 3 && s < 13)) begin
        n_fail++; $display("FAIL pipe_valid_timing step %0d: got %b expected %b", s, ofire, (s >= 3 && s < 13));
      end
      if (s < 10) begin
        n_checks++;
        if (ifire !== 1'b1) begin
          n_fail++; $display("FAIL pipe_accept step %0d: got ready=%b expected 1", s, ifire);
        end
      end
      if (ofire) begin
        n_checks++;
        if (!hexp || obs !== exp) begin
          n_fail++; $display("FAIL pipe_data step %0d: got %h expected %h (had_expected=%b)", s, obs, exp, hexp);
        end
      end
`ifdef PPL_HS_OCC_CNT_EN
      n_checks++;
      if (occ_v[3] !== 4'(sb_q.size())) begin
        n_fail++; $display("FAIL pipe_occ step %0d: got %0d expected %0d", s, occ_v[3], sb_q.size());
      end
`endif
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL pipe_drained: got %0d beats left expected 0", sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ofire, hexp, ifire;
    logic [DW-1:0] obs, exp;
    int acc = 0;
    int n_out = 0;
    sb_q.delete();
    for (int s = 0; s < 8; s++) begin
      step(2, 1'b1, DW'(32'h10 + s), 1'b0, ofire, obs, exp, hexp, ifire);
      if (ifire) acc++;
      n_checks++;
      if (ifire !== (s < 4)) begin
        n_fail++; $display("FAIL bp_accept step %0d: got %b expected %b", s, ifire, (s < 4));
      end
    end
    n_checks++;
    if (acc != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d expected 4", acc);
    end
    n_checks++;
    if (rdy_o[2] !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready: got %b expected 0", rdy_o[2]);
    end
    n_checks++;
    if (v_out[2] !== 1'b1 || dout[2] !== 32'h10) begin
      n_fail++; $display("FAIL bp_head: got valid=%b data=%h expected valid=1 data=00000010", v_out[2], dout[2]);
    end
`ifdef PPL_HS_OCC_CNT_EN
    n_checks++;
    if (occ_v[2] !== 4'd4) begin
      n_fail++; $display("FAIL bp_occ: got %0d expected 4", occ_v[2]);
    end
`endif
    for (int s = 0; s < 8; s++) begin
      step(2, 1'b0, '0, 1'b1, ofire, obs, exp, hexp, ifire);
      if (ofire) begin
        n_out++;
        n_checks++;
        if (!hexp || obs !== exp) begin
          n_fail++; $display("FAIL bp_drain_data: got %h expected %h (had_expected=%b)", obs, exp, hexp);
        end
      end
    end
    n_checks++;
    if (n_out != 4 || v_out[2] !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain_count: got %0d beats valid=%b expected 4 beats valid=0", n_out, v_out[2]);
    end
  endtask

  task automatic test_toggle();
    bit ofire, hexp, ifire, rin, held, pre_v;
    logic [DW-1:0] obs, exp, held_d, pre_d;
    int idx = 0;
    int n_out = 0;
    held = 1'b0;
    held_d = '0;
    sb_q.delete();
    for (int s = 0; s < 40 && n_out < 8; s++) begin
      rin = (s % 2 == 0);
      if (held) begin
        n_checks++;
        if (v_out[1] !== 1'b1 || dout[1] !== held_d) begin
          n_fail++; $display("FAIL toggle_hold step %0d: got valid=%b data=%h expected valid=1 data=%h", s, v_out[1], dout[1], held_d);
        end
      end
      pre_v = v_out[1];
      pre_d = dout[1];
      step(1, idx < 8, DW'(32'hA0 + idx), rin, ofire, obs, exp, hexp, ifire);
      if (ifire) idx++;
      if (ofire) begin
        n_out++;
        n_checks++;
        if (!hexp || obs !== exp) begin
          n_fail++; $display("FAIL toggle_data step %0d: got %h expected %h (had_expected=%b)", s, obs, exp, hexp);
        end
      end
      held   = pre_v & !rin;
      held_d = pre_d;
    end
    n_checks++;
    if (n_out != 8 || idx != 8 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL toggle_count: got out=%0d in=%0d left=%0d expected 8/8/0", n_out, idx, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ofire, hexp, ifire;
    logic [DW-1:0] obs, exp;
    int n_out = 0;
    sb_q.delete();
    for (int s = 0; s < 3; s++) begin
      step(2, 1'b1, DW'(32'h30 + s), 1'b0, ofire, obs, exp, hexp, ifire);
    end
`ifdef PPL_HS_OCC_CNT_EN
    n_checks++;
    if (occ_v[2] !== 4'd3) begin
      n_fail++; $display("FAIL rstmid_occ_before: got %0d expected 3", occ_v[2]);
    end
`endif
    v_in[2] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (v_out[2] !== 1'b0 || rdy_o[2] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: got valid=%b ready=%b expected 0/0", v_out[2], rdy_o[2]);
    end
`ifdef PPL_HS_OCC_CNT_EN
    n_checks++;
    if (occ_v[2] !== 4'd0) begin
      n_fail++; $display("FAIL rstmid_occ: got %0d expected 0", occ_v[2]);
    end
`endif
    #1 rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    n_checks++;
    if (rdy_o[2] !== 1'b1 || v_out[2] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_release: got ready=%b valid=%b expected 1/0", rdy_o[2], v_out[2]);
    end
    for (int s = 0; s < 6; s++) begin
      step(2, s == 0, 32'h55, 1'b1, ofire, obs, exp, hexp, ifire);
      n_checks++;
      if (ofire !== (s == 2)) begin
        n_fail++; $display("FAIL rstmid_timing step %0d: got %b expected %b", s, ofire, (s == 2));
      end
      if (ofire) begin
        n_out++;
        n_checks++;
        if (!hexp || obs !== 32'h55) begin
          n_fail++; $display("FAIL rstmid_data: got %h expected 00000055", obs);
        end
      end
    end
    n_checks++;
    if (n_out != 1) begin
      n_fail++; $display("FAIL rstmid_count: got %0d beats expected 1", n_out);
    end
  endtask

  task automatic test_passthru();
    logic v, r;
    logic [DW-1:0] d;
    for (int k = 0; k < 6; k++) begin
      v = k[0];
      r = k[1];
      d = $urandom;
      v_in[0] = v; r_in[0] = r; din[0] = d;
      #1;
      n_checks++;
      if (v_out[0] !== v || rdy_o[0] !== r || dout[0] !== d) begin
        n_fail++;
        $display("FAIL passthru %0d: got v=%b r=%b d=%h expected v=%b r=%b d=%h", k, v_out[0], rdy_o[0], dout[0], v, r, d);
      end
`ifdef PPL_HS_OCC_CNT_EN
      n_checks++;
      if (occ_v[0] !== 4'd0) begin
        n_fail++; $display("FAIL passthru_occ: got %0d expected 0", occ_v[0]);
      end
`endif
    end
    v_in[0] = 1'b0; r_in[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ofire, hexp, ifire, rin, vin, held, pre_v;
    logic [DW-1:0] obs, exp, held_d, pre_d;
    int cnt = 0;
    held = 1'b0;
    held_d = '0;
    sb_q.delete();
    for (int s = 0; s < 10000; s++) begin
      vin = 1'($urandom_range(0, 1));
      rin = 1'($urandom_range(0, 1));
      if (held) begin
        n_checks++;
        if (v_out[4] !== 1'b1 || dout[4] !== held_d) begin
          n_fail++; $display("FAIL rand_hold step %0d: got valid=%b data=%h expected valid=1 data=%h", s, v_out[4], dout[4], held_d);
        end
      end
      pre_v = v_out[4];
      pre_d = dout[4];
      step(4, vin, DW'(cnt), rin, ofire, obs, exp, hexp, ifire);
      if (ifire) cnt++;
      if (ofire) begin
        n_checks++;
        if (!hexp || obs !== exp) begin
          n_fail++; $display("FAIL rand_data step %0d: got %h expected %h (had_expected=%b)", s, obs, exp, hexp);
        end
      end
      n_checks++;
      if (sb_q.size() > 8) begin
        n_fail++; $display("FAIL rand_capacity step %0d: got %0d held expected <= 8", s, sb_q.size());
      end
`ifdef PPL_HS_OCC_CNT_EN
      n_checks++;
      if (occ_v[4] !== 4'(sb_q.size())) begin
        n_fail++; $display("FAIL rand_occ step %0d: got %0d expected %0d", s, occ_v[4], sb_q.size());
      end
`endif
      held   = pre_v & !rin;
      held_d = pre_d;
    end
    for (int s = 0; s < 40; s++) begin
      step(4, 1'b0, '0, 1'b1, ofire, obs, exp, hexp, ifire);
      if (ofire) begin
        n_checks++;
        if (!hexp || obs !== exp) begin
          n_fail++; $display("FAIL rand_drain step %0d: got %h expected %h (had_expected=%b)", s, obs, exp, hexp);
        end
      end
    end
    n_checks++;
    if (sb_q.size() != 0 || v_out[4] !== 1'b0) begin
      n_fail++; $display("FAIL rand_drained: got %0d left valid=%b expected 0/0", sb_q.size(), v_out[4]);
    end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    test_passthru();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
